// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are 7 bits {a,b,c,d,e,f,g}. They are active-low, so 0 lights a segment.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] SSEG_OFF  = 8'hFF;

  // Hex glyphs. The highest entry (F) is written first, so SEG_TABLE[n] is the glyph for n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-nibble to 7-segment decoder. The output is active-low.
//   nibble_i : hex digit 0..F
//   seg_o    : {a,b,c,d,e,f,g}, 0 = lit
module seg_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_decode(nibble_i);
  end

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Each digit gets one slot of REFRESH_DIV cycles.
// The first BLANK_CYCLES cycles of every slot keep all anodes off to avoid ghosting.
// Digit inputs are snapshotted once per frame, so a frame never shows a mix of old and new values.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; while low the scan holds and the display is dark
//   value       : NUM_DIGITS hex nibbles; digit 0 is the rightmost
//   dp          : per-digit decimal point request (1 = lit)
//   digit_en    : per-digit enable (0 = blank)
//   lz_suppress : blank leading zero digits (digit 0 is never suppressed)
//   an          : active-low anode selects
//   sseg        : {dp,a,b,c,d,e,f,g}, active-low
//   frame_tick  : one-cycle pulse after each completed frame
module sseg_mux_driver
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK  = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_value_q, snap_value_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_den_q, snap_den_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;
  logic                    frame_tick_q, frame_tick_d;

  logic       slot_end, frame_end, upper_zero, blanked;
  logic [3:0] cur_nibble;
  logic [6:0] cur_seg;

  seg_decoder u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  always_comb begin
    slot_end  = en && (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en) begin
      if (slot_end) begin
        cnt_d = '0;
        idx_d = frame_end ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Inputs are re-sampled while idle as well, so a restarted scan shows fresh data.
    snap_value_d = snap_value_q;
    snap_dp_d    = snap_dp_q;
    snap_den_d   = snap_den_q;
    if (!en || frame_end) begin
      snap_value_d = value;
      snap_dp_d    = dp;
      snap_den_d   = digit_en;
    end

    cur_nibble = snap_value_q[idx_q*4 +: 4];
    // This digit and everything to its left are zero, so it is a leading zero.
    upper_zero = (snap_value_q >> {idx_q, 2'b00}) == '0;
    blanked    = !snap_den_q[idx_q] || (lz_suppress && (idx_q != '0) && upper_zero);

    an_d   = '1;
    sseg_d = SSEG_OFF;
    if (en && (cnt_q >= CNT_BLANK) && !blanked) begin
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
      sseg_d = {~snap_dp_q[idx_q], cur_seg};
    end

    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_value_q <= '0;
      snap_dp_q    <= '0;
      snap_den_q   <= '0;
      an_q         <= '1;
      sseg_q       <= SSEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_den_q   <= snap_den_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Scoreboard bench for sseg_mux_driver with NUM_DIGITS=4, REFRESH_DIV=4 and BLANK_CYCLES=1.
// A reference model tracks the total number of enabled cycles since reset.
// It derives the digit and slot position from that count with division and modulo.
// It pushes one expected output word per clock edge into a queue.
// A monitor pops and compares on the falling edge.
module tb_sseg_mux_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;
  localparam int unsigned BL = 1;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ft;
  } out_t;

  localparam out_t OFF = '{an: 4'hF, sseg: 8'hFF, ft: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_tick;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  sseg_mux_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .value       (value),
    .dp          (dp),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .an          (an),
    .sseg        (sseg),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Glyph table, indexed by hex digit: {a..g}, active-low.
  logic [6:0] DEC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state.
  int unsigned m_t;
  int unsigned m_idx;
  int unsigned m_cnt;
  bit          m_fb;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_den;
  out_t        m_e;
  out_t        exp_q[$];

  function automatic bit model_blank(int unsigned d);
    bit allz;
    if (!m_den[d]) return 1'b1;
    if (lz_suppress && d != 0) begin
      allz = 1'b1;
      for (int unsigned k = d; k < ND; k++)
        if (m_val[4*k +: 4] != 4'h0) allz = 1'b0;
      return allz;
    end
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t   = 0;
      m_val = '0;
      m_dp  = '0;
      m_den = '0;
      exp_q.delete();
    end else begin
      m_idx = (m_t / RD) % ND;
      m_cnt = m_t % RD;
      m_fb  = en && ((m_t % (RD*ND)) == RD*ND - 1);
      m_e   = OFF;
      m_e.ft = m_fb;
      if (en && m_cnt >= BL && !model_blank(m_idx)) begin
        m_e.an[m_idx] = 1'b0;
        m_e.sseg = {~m_dp[m_idx], DEC[m_val[4*m_idx +: 4]]};
      end
      exp_q.push_back(m_e);
      if (!en || m_fb) begin
        m_val = value;
        m_dp  = dp;
        m_den = digit_en;
      end
      if (en) m_t++;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  out_t mon_e;
  always @(negedge clk) begin
    if (!rst_n || exp_q.size() == 0) mon_e = OFF;
    else mon_e = exp_q.pop_front();
    chk("an",         {4'h0, an},         {4'h0, mon_e.an});
    chk("sseg",       sseg,               mon_e.sseg);
    chk("frame_tick", {7'h0, frame_tick}, {7'h0, mon_e.ft});
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    cyc(3);
    // Reset and idle: start a scan, then reset mid-frame.
    rst_n = 1'b1; value = 16'h3210; digit_en = 4'hF; dp = 4'b0100;
    cyc(2);
    en = 1'b1;
    cyc(7);
    rst_n = 1'b0;
    cyc(2);
    en = 1'b0;
    rst_n = 1'b1;
    cyc(4);

    // Basic scan
    en = 1'b1;
    cyc(40);

    // Tearing: new value mid-frame, during digit 1.
    while (m_t % (RD*ND) != 6) cyc(1);
    value = 16'hFFFF;
    cyc(36);

    // Leading-zero suppression
    lz_suppress = 1'b1; value = 16'h0050;
    cyc(40);
    value = 16'h0000;
    cyc(40);
    lz_suppress = 1'b0; value = 16'h3210;

    // Enable drop at digit 2, cnt 2.
    begin
      int unsigned guard = 0;
      while (m_t % (RD*ND) != 10 && guard < 40) begin
        cyc(1);
        guard++;
      end
    end
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(20);

    // Digit enables
    digit_en = 4'b1010; dp = 4'hF;
    cyc(40);

    // Randomised run
    for (int unsigned i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 29) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 15) == 0) value = {12'h000, 4'($urandom)};
      en = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cyc(1);
      rst_n = 1'b1;
    end
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
